// File: rtl/time_disp_pkg.sv
// Shared constants for the time display scanner: digit count, default clock
// and the active-low {g,f,e,d,c,b,a} segment font.
package time_disp_pkg;

  localparam int NUM_DIGITS     = 6;
  localparam int DEFAULT_CLK_HZ = 25_000_000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } snapshot_t;

  function automatic logic [6:0] seg_font(input logic [3:0] code);
    logic [6:0] glyph;
    case (code)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/time_display_scan_bin2bcd6.sv
// bin2bcd6: combinational 6-bit binary (0..63) to two BCD digits.
// Values 60..63 yield tens=6, so they display literally.
module bin2bcd6
  import time_disp_pkg::*;
(
  input  logic [5:0] bin,
  output logic [2:0] tens,
  output logic [3:0] units
);

  // Compare-and-subtract ladder; avoids a generic divider.
  always_comb begin
    tens  = 3'd0;
    units = 4'd0;
    if (bin >= 6'd60) begin
      tens  = 3'd6;
      units = 4'(bin - 6'd60);
    end else if (bin >= 6'd50) begin
      tens  = 3'd5;
      units = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens  = 3'd4;
      units = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens  = 3'd3;
      units = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens  = 3'd2;
      units = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens  = 3'd1;
      units = 4'(bin - 6'd10);
    end else begin
      tens  = 3'd0;
      units = bin[3:0];
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: snapshots hours/minutes/seconds once per frame and scans
// six digits onto a common-anode display. Optional macro: COLON_BLINK_EN.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int DIGIT_HZ = 1000,
  parameter int DIV_W    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] value1,
  input  logic [5:0] value2,
  input  logic [5:0] value3,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int              DIV      = CLK_HZ / DIGIT_HZ;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] prescaler_r;
  logic [2:0]       idx_r;
  snapshot_t        snap_r;
  logic             tick_s;

  logic [5:0]       sel_value_s;
  logic [2:0]       tens_s;
  logic [3:0]       units_s;
  logic [3:0]       digit_s;
  logic [5:0]       an_next_s;
  logic             dp_next_s;

  logic [5:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic             frame_start_r;

  assign tick_s = (prescaler_r == DIV_LAST);

  // Prescaler and digit index; the index steps once per tick and wraps 5->0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_r <= '0;
      idx_r       <= 3'd0;
    end else if (tick_s) begin
      prescaler_r <= '0;
      idx_r       <= (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
    end else begin
      prescaler_r <= prescaler_r + DIV_W'(1);
      idx_r       <= idx_r;
    end
  end

  // Snapshot at the end of the last slot so a frame never mixes two captures.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_r <= '0;
    end else if (tick_s && (idx_r == LAST_IDX)) begin
      snap_r <= {value1, value2, value3};
    end else begin
      snap_r <= snap_r;
    end
  end

  // Slot pair selects the field; even slots show tens, odd slots units.
  always_comb begin
    sel_value_s = snap_r.hours;
    an_next_s   = 6'b111111;
    case (idx_r)
      3'd0: begin sel_value_s = snap_r.hours;   an_next_s = 6'b011111; end
      3'd1: begin sel_value_s = snap_r.hours;   an_next_s = 6'b101111; end
      3'd2: begin sel_value_s = snap_r.minutes; an_next_s = 6'b110111; end
      3'd3: begin sel_value_s = snap_r.minutes; an_next_s = 6'b111011; end
      3'd4: begin sel_value_s = snap_r.seconds; an_next_s = 6'b111101; end
      3'd5: begin sel_value_s = snap_r.seconds; an_next_s = 6'b111110; end
      default: begin sel_value_s = snap_r.hours; an_next_s = 6'b111111; end
    endcase
  end

  bin2bcd6 u_bin2bcd6 (
    .bin   (sel_value_s),
    .tens  (tens_s),
    .units (units_s)
  );

  always_comb begin
    digit_s = 4'd0;
    if (idx_r[0]) begin
      digit_s = units_s;
    end else begin
      digit_s = {1'b0, tens_s};
    end
  end

`ifdef COLON_BLINK_EN
  localparam int BLINK_HALF = CLK_HZ / 2;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_r;

  // Half-second divider toggling the colon flag (1 Hz blink).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      blink_r     <= blink_r;
    end
  end

  always_comb begin
    dp_next_s = 1'b1;
    if (blink_r && ((idx_r == 3'd1) || (idx_r == 3'd3))) begin
      dp_next_s = 1'b0;
    end else begin
      dp_next_s = 1'b1;
    end
  end
`else
  assign dp_next_s = 1'b1;
`endif

  // Display registers load on tick from the slot that just completed its count;
  // frame_start is pre-decoded one cycle early so it aligns with the capture tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_r          <= 6'b111111;
      seg_r         <= SEG_BLANK;
      dp_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= (prescaler_r == DIV_PRE) && (idx_r == LAST_IDX);
      if (tick_s) begin
        an_r  <= an_next_s;
        seg_r <= seg_font(digit_s);
        dp_r  <= dp_next_s;
      end else begin
        an_r  <= an_r;
        seg_r <= seg_r;
        dp_r  <= dp_r;
      end
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign dp          = dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench for time_display_scan (DIV=4) against a frame-level
// arithmetic model of what each digit slot should show.
module tb_time_display_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;
  localparam int HALF  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] value1, value2, value3;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [17:0] caps [0:255];
  logic [6:0]  font [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [14:0] exp_v;

  time_display_scan #(.CLK_HZ(8), .DIGIT_HZ(2), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .value1(value1), .value2(value2), .value3(value3),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Model time base: edges since reset, and a capture every FRAME edges.
  always @(posedge clk) begin
    if (!rst_n) begin
      t <= 0;
    end else begin
      t <= t + 1;
      if ((t + 1) % FRAME == 0) caps[((t + 1) / FRAME) % 256] <= {value1, value2, value3};
    end
  end

  // Expected {an, seg, dp, frame_start} after edge tt.
  function automatic logic [14:0] model_out(int tt);
    int m, slot, f, v, d;
    logic [17:0] snap;
    logic [5:0] a;
    logic p, fs;
    fs = ((tt + 1) % FRAME == 0);
    if (tt < DIV) return {6'h3F, 7'h7F, 1'b1, fs};
    m    = tt / DIV;
    slot = (m - 1) % 6;
    f    = (m - 1) / 6;
    snap = (f == 0) ? 18'd0 : caps[f % 256];
    if (slot / 2 == 0)      v = int'(snap[17:12]);
    else if (slot / 2 == 1) v = int'(snap[11:6]);
    else                    v = int'(snap[5:0]);
    d = (slot % 2 == 0) ? v / 10 : v % 10;
    a = 6'h3F;
    a[5 - slot] = 1'b0;
    p = 1'b1;
`ifdef COLON_BLINK_EN
    if ((slot == 1 || slot == 3) && (((DIV * m - 1) / HALF) % 2 == 1)) p = 1'b0;
`endif
    return {a, font[d], p, fs};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    value1 = 6'd12; value2 = 6'd34; value3 = 6'd56;
    repeat (3) @(negedge clk);
    checks++; if (an !== 6'b111111) begin errors++; $display("FAIL reset_an got=%b exp=111111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    rst_n = 1'b1;
    for (int k = 1; k <= DIV; k++) begin
      @(negedge clk);
      checks++;
      if (k < DIV && ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1})) begin
        errors++; $display("FAIL pre_tick k=%0d got an=%b seg=%b dp=%b exp blank", k, an, seg, dp);
      end else if (k == DIV && ({an, seg} !== {6'b011111, 7'b1000000})) begin
        errors++; $display("FAIL first_tick got an=%b seg=%b exp an=011111 seg=1000000", an, seg);
      end
    end
  endtask

  task automatic test_frame();
    int dig;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      exp_v = model_out(t);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_v) begin
        errors++; $display("FAIL frame t=%0d got=%b exp=%b", t, {an, seg, dp, frame_start}, exp_v);
      end
      checks++;
      if ($countones(~an) != 1) begin errors++; $display("FAIL one_hot t=%0d got an=%b exp one low bit", t, an); end
      if (t >= FRAME + DIV && t < 2 * FRAME + DIV && (t % DIV) == 0) begin
        dig = t / DIV - 7;
        checks++;
        if (seg !== font[dig + 1] || an[5 - dig] !== 1'b0) begin
          errors++; $display("FAIL digit_seq slot=%0d got seg=%b an=%b exp seg=%b", dig, seg, an, font[dig + 1]);
        end
      end
    end
  endtask

  task automatic test_no_tearing();
    int guard = 0;
    while ((t % FRAME) != 8 && guard < 2 * FRAME) begin
      @(negedge clk); guard++;
    end
    checks++;
    if ((t % FRAME) != 8) begin errors++; $display("FAIL tear_sync got t=%0d exp t%%%0d=8", t, FRAME); end
    value2 = 6'd9;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      exp_v = model_out(t);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_v) begin
        errors++; $display("FAIL no_tearing t=%0d got=%b exp=%b", t, {an, seg, dp, frame_start}, exp_v);
      end
    end
  endtask

  task automatic test_boundary();
    value3 = 6'd63; value1 = 6'd0;
    for (int k = 0; k < 2 * FRAME + DIV; k++) begin
      @(negedge clk);
      exp_v = model_out(t);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_v) begin
        errors++; $display("FAIL boundary t=%0d got=%b exp=%b", t, {an, seg, dp, frame_start}, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 40; n++) begin
      value1 = 6'($urandom_range(0, 63));
      value2 = 6'($urandom_range(0, 63));
      value3 = 6'($urandom_range(0, 63));
      hold = $urandom_range(1, 30);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        exp_v = model_out(t);
        checks++;
        if ({an, seg, dp, frame_start} !== exp_v) begin
          errors++; $display("FAIL random t=%0d got=%b exp=%b", t, {an, seg, dp, frame_start}, exp_v);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    int cnt = 0;
    while (!(t >= DIV && ((t / DIV) % 6) == 3 && (t % DIV) == 1) && guard < 2 * FRAME) begin
      @(negedge clk); guard++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_reset got an=%b seg=%b dp=%b fs=%b exp blank", an, seg, dp, frame_start);
    end
    rst_n = 1'b1;
    while (cnt < 3 * FRAME) begin
      @(negedge clk);
      cnt++;
      exp_v = model_out(t);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_v) begin
        errors++; $display("FAIL after_reset t=%0d got=%b exp=%b", t, {an, seg, dp, frame_start}, exp_v);
      end
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (cnt != FRAME - 1) begin errors++; $display("FAIL fs_latency got=%0d exp=%0d", cnt, FRAME - 1); end
  endtask

  initial begin
    rst_n = 1'b0;
    value1 = 6'd0; value2 = 6'd0; value3 = 6'd0;
    test_reset();
    test_frame();
    test_no_tearing();
    test_boundary();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
